// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: size codes (also used by the
// instruction decoder's memory-size field), FSM states and grant owners.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } grant_e;

  function automatic logic is_legal_req(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size_e'(size))
      SZ_NONE: ok = 1'b0;
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (addr_lo[0] == 1'b0);
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One request/response channel. The same bundle serves the CPU, debug and
// memory sides; on the memory side ready carries mem_ack and err is unused.
interface mem_bus_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, size, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, size, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mem_bus_arbiter_bus_timeout_counter.sv
// Wait-cycle counter with expiry compare for the BUS state; present only
// when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic ack_i,
  output logic expired_o
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count un-acked BUS cycles; outside BUS the counter sits at zero.
  always_comb begin
    cnt_d = {CNT_W{1'b0}};
    if (run_i && !ack_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires in the cycle whose count would reach TIMEOUT_CYCLES; an ack wins.
  assign expired_o = run_i && !ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between CPU and debug ports.
// Optional ack timeout is enabled with the ARB_TIMEOUT_EN macro.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  cpu_bus,
  mem_bus_arbiter_if.slave  dbg_bus,
  mem_bus_arbiter_if.master mem_bus
);

  state_e      state_q, state_d;
  grant_e      last_gnt_q, last_gnt_d;
  grant_e      gnt_q, gnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        cpu_err_q, cpu_err_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        dbg_ready_q, dbg_ready_d;
  logic        dbg_err_q, dbg_err_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;

  logic        win_dbg_s;
  logic        timeout_s;
  logic        done_s;
  logic        done_err_s;
  logic [31:0] done_rdata_s;
  logic        unused_s;

`ifdef ARB_TIMEOUT_EN
  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .run_i    (state_q == ST_BUS),
    .ack_i    (mem_bus.ready),
    .expired_o(timeout_s)
  );
  assign unused_s = mem_bus.err;
`else
  assign timeout_s = 1'b0;
  assign unused_s  = ^{mem_bus.err, TIMEOUT_CYCLES[0]};
`endif

  // Debug wins when alone, or in contention when the CPU had the last grant.
  assign win_dbg_s = dbg_bus.req && (!cpu_bus.req || (last_gnt_q == GNT_CPU));

  // Next-state logic: grant/legality in IDLE, ack or timeout in BUS.
  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    gnt_d        = gnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_size_d   = mem_size_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ready_d  = 1'b0;
    cpu_err_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_ready_d  = 1'b0;
    dbg_err_d    = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;
    done_s       = 1'b0;
    done_err_s   = 1'b0;
    done_rdata_s = 32'h0000_0000;

    case (state_q)
      ST_IDLE: begin
        if (cpu_bus.req || dbg_bus.req) begin
          gnt_d       = win_dbg_s ? GNT_DBG : GNT_CPU;
          last_gnt_d  = gnt_d;
          mem_we_d    = win_dbg_s ? dbg_bus.we    : cpu_bus.we;
          mem_size_d  = win_dbg_s ? dbg_bus.size  : cpu_bus.size;
          mem_addr_d  = win_dbg_s ? dbg_bus.addr  : cpu_bus.addr;
          mem_wdata_d = win_dbg_s ? dbg_bus.wdata : cpu_bus.wdata;
          if (is_legal_req(mem_size_d, mem_addr_d[1:0])) begin
            mem_req_d = 1'b1;
            state_d   = ST_BUS;
          end else begin
            done_s     = 1'b1;
            done_err_s = 1'b1;
            state_d    = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (mem_bus.ready) begin
          mem_req_d    = 1'b0;
          done_s       = 1'b1;
          done_rdata_s = mem_we_q ? 32'h0000_0000 : mem_bus.rdata;
          state_d      = ST_DONE;
        end else if (timeout_s) begin
          mem_req_d  = 1'b0;
          done_s     = 1'b1;
          done_err_s = 1'b1;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    if (done_s) begin
      if (gnt_d == GNT_DBG) begin
        dbg_ready_d = 1'b1;
        dbg_err_d   = done_err_s;
        dbg_rdata_d = done_rdata_s;
      end else begin
        cpu_ready_d = 1'b1;
        cpu_err_d   = done_err_s;
        cpu_rdata_d = done_rdata_s;
      end
    end else begin
      cpu_ready_d = 1'b0;
      dbg_ready_d = 1'b0;
    end
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= GNT_DBG;
      gnt_q       <= GNT_CPU;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'd0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= 32'h0000_0000;
      dbg_ready_q <= 1'b0;
      dbg_err_q   <= 1'b0;
      dbg_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_ready_q <= dbg_ready_d;
      dbg_err_q   <= dbg_err_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign mem_bus.req   = mem_req_q;
  assign mem_bus.we    = mem_we_q;
  assign mem_bus.size  = mem_size_q;
  assign mem_bus.addr  = mem_addr_q;
  assign mem_bus.wdata = mem_wdata_q;
  assign cpu_bus.ready = cpu_ready_q;
  assign cpu_bus.err   = cpu_err_q;
  assign cpu_bus.rdata = cpu_rdata_q;
  assign dbg_bus.ready = dbg_ready_q;
  assign dbg_bus.err   = dbg_err_q;
  assign dbg_bus.rdata = dbg_rdata_q;

endmodule
